vector_load_unit: RTL and testbench

VECTOR_LOAD_UNIT -- requirements
Module: vector_load_unit

---
 rtl/vector_load_unit_if.sv | 16 +
 rtl/vector_load_unit.sv | 94 +++++++++
 tb/tb_vector_load_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vector_load_unit_if.sv
// vector_load_unit_if: request, memory-read and register-file write bundle of the vector load unit.
interface vector_load_unit_if #(parameter int ADDR_W = 16, parameter int LANES = 6);
  logic req_valid, req_ready, req_scalar, mem_re, we3, wsflag, ldsflag, done, err;
  logic [ADDR_W-1:0] req_addr, mem_addr;
  logic [3:0] req_dst, a3;
  logic [7:0] mem_rdata;
  logic [LANES*8-1:0] wd3;
  modport master(
    output req_valid, req_addr, req_dst, req_scalar, mem_rdata,
    input req_ready, mem_re, mem_addr, we3, wsflag, ldsflag, a3, wd3, done, err
  );
  modport slave(
    input req_valid, req_addr, req_dst, req_scalar, mem_rdata,
    output req_ready, mem_re, mem_addr, we3, wsflag, ldsflag, a3, wd3, done, err
  );
endinterface

// File: rtl/vector_load_unit.sv
// vector_load_unit: gathers LANES bytes (or one scalar byte) from data memory into a register-file write.
module vector_load_unit #(
  parameter int ADDR_W = 16,
  parameter int LANES = 6
) (
  input logic clk,
  input logic reset,
  vector_load_unit_if.slave bus
);
  localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int CW = $clog2(LANES + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] cidx;
  logic cap_v, scalar;
  logic [3:0] dst;
  logic [LANES*8-1:0] lbuf, nbuf;
  // nbuf folds in the byte arriving this cycle so DRAIN can write the complete vector
  always_comb begin
    nbuf = lbuf;
    if (cap_v) nbuf[8*cidx +: 8] = bus.mem_rdata;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bus.req_ready <= 1'b1;
      bus.mem_re <= 1'b0;
      bus.mem_addr <= '0;
      bus.we3 <= 1'b0;
      bus.wsflag <= 1'b0;
      bus.ldsflag <= 1'b0;
      bus.a3 <= '0;
      bus.wd3 <= '0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      cnt <= '0;
      cidx <= '0;
      cap_v <= 1'b0;
      scalar <= 1'b0;
      dst <= '0;
      lbuf <= '0;
    end else begin
      bus.we3 <= 1'b0;
      bus.wsflag <= 1'b0;
      bus.ldsflag <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      cap_v <= bus.mem_re;
      lbuf <= nbuf;
      if (cap_v) cidx <= cidx + 1'b1;
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            dst <= bus.req_dst;
            scalar <= bus.req_scalar;
            lbuf <= '0;
            cidx <= '0;
            // an out-of-range scalar lane is consumed with only an err pulse
            if (bus.req_scalar && 32'(bus.req_dst) >= LANES) bus.err <= 1'b1;
            else begin
              state <= READ;
              bus.mem_re <= 1'b1;
              bus.mem_addr <= bus.req_addr;
              cnt <= bus.req_scalar ? CW'(1) : CW'(LANES);
            end
          end
        end
        READ:
          if (cnt == CW'(1)) begin
            bus.mem_re <= 1'b0;
            state <= DRAIN;
          end else begin
            bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
            cnt <= cnt - 1'b1;
          end
        DRAIN: begin
          state <= WRITE;
          bus.we3 <= 1'b1;
          bus.done <= 1'b1;
          bus.wsflag <= scalar;
          bus.ldsflag <= scalar;
          bus.a3 <= dst;
          bus.wd3 <= nbuf;
        end
        WRITE: begin
          state <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_vector_load_unit.sv
// tb_vector_load_unit: directed and randomized checks of vector_load_unit against a cycle-schedule model.
module tb_vector_load_unit;
  localparam int LANES = 6;
  localparam int MAXC = 2000;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] mem [0:65535];
  bit e_ready [MAXC], e_re [MAXC], e_we [MAXC], e_sf [MAXC], e_err [MAXC], e_rst [MAXC];
  logic [15:0] e_addr [MAXC];
  logic [3:0] e_a3 [MAXC];
  logic [47:0] e_wd3 [MAXC];
  logic [3:0] h_a3;
  logic [47:0] h_wd3;
  logic pend;
  logic [15:0] paddr;
  vector_load_unit_if #(.ADDR_W(16), .LANES(LANES)) bus ();
  vector_load_unit #(.ADDR_W(16), .LANES(LANES)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // memory answers one cycle after the strobe; noise otherwise exposes mistimed captures
  always @(negedge clk) begin
    pend = bus.mem_re;
    paddr = bus.mem_addr;
  end
  always @(posedge clk) begin
    #1;
    bus.mem_rdata = pend ? mem[paddr] : 8'($urandom);
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask
  task automatic clr(input int from);
    for (int k = from; k < MAXC; k++) begin
      e_ready[k] = 1; e_re[k] = 0; e_we[k] = 0; e_sf[k] = 0; e_err[k] = 0; e_rst[k] = 0;
      e_addr[k] = '0; e_a3[k] = '0; e_wd3[k] = '0;
    end
  endtask
  task automatic sched(input int c, input logic [15:0] a, input logic [3:0] d, input logic sc);
    int n;
    logic [47:0] w;
    logic [15:0] ai;
    if (sc && d >= LANES) begin
      e_ready[c+1] = 0;
      e_err[c+1] = 1;
    end else begin
      n = sc ? 1 : LANES;
      w = '0;
      for (int i = 0; i < n; i++) begin
        ai = a + 16'(i);
        e_re[c+1+i] = 1;
        e_addr[c+1+i] = ai;
        w[8*i +: 8] = mem[ai];
      end
      for (int k = 1; k <= n + 2; k++) e_ready[c+k] = 0;
      e_we[c+n+2] = 1; e_sf[c+n+2] = sc; e_a3[c+n+2] = d; e_wd3[c+n+2] = w;
    end
  endtask
  always @(negedge clk)
    if (cyc > 0 && cyc < MAXC) begin
      if (e_rst[cyc]) begin
        h_a3 = '0;
        h_wd3 = '0;
      end else if (e_we[cyc]) begin
        h_a3 = e_a3[cyc];
        h_wd3 = e_wd3[cyc];
      end
      chk("req_ready", bus.req_ready, e_ready[cyc]);
      chk("mem_re", bus.mem_re, e_re[cyc]);
      if (e_re[cyc]) chk("mem_addr", bus.mem_addr, e_addr[cyc]);
      chk("we3", bus.we3, e_we[cyc]);
      chk("done", bus.done, e_we[cyc]);
      chk("wsflag", bus.wsflag, e_sf[cyc]);
      chk("ldsflag", bus.ldsflag, e_sf[cyc]);
      chk("err", bus.err, e_err[cyc]);
      chk("a3", bus.a3, h_a3);
      chk("wd3", bus.wd3, h_wd3);
    end
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic step(input logic v, input logic [15:0] ad, input logic [3:0] d, input logic sc);
    bus.req_valid = v; bus.req_addr = ad; bus.req_dst = d; bus.req_scalar = sc;
    if (v && !reset && e_ready[cyc] && cyc + LANES + 3 < MAXC) sched(cyc, ad, d, sc);
    tick();
  endtask
  task automatic idle();
    step(1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
  endtask
  task automatic rst_cycles(input int n);
    reset = 1'b1;
    bus.req_valid = 1'b0;
    clr(cyc);
    repeat (n) begin
      e_rst[cyc] = 1;
      tick();
    end
    reset = 1'b0;
  endtask
  initial begin
    int a, last;
    logic [15:0] wexp [6];
    wexp = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
    for (int k = 0; k < 65536; k++) mem[k] = 8'($urandom);
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_dst = '0; bus.req_scalar = 1'b0;
    rst_cycles(3);
    chk("reset_ready", bus.req_ready, 1'b1);
    chk("reset_wd3", bus.wd3, 48'h0);
    idle();
    for (int i = 0; i < 6; i++) mem[16'h10 + i] = 8'(8'h11 * (i + 1));
    a = cyc;
    step(1'b1, 16'h0010, 4'd3, 1'b0);
    chk("model_vec_wd3", e_wd3[a+8], 48'h665544332211);
    for (int i = 0; i < 6; i++) begin
      chk("vec_re", bus.mem_re, 1'b1);
      chk("vec_addr", bus.mem_addr, 16'h0010 + 16'(i));
      idle();
    end
    idle();
    chk("vec_we3", bus.we3, 1'b1);
    chk("vec_a3", bus.a3, 4'd3);
    chk("vec_wd3", bus.wd3, 48'h665544332211);
    idle();
    chk("vec_ready", bus.req_ready, 1'b1);
    mem[16'h0040] = 8'hA5;
    step(1'b1, 16'h0040, 4'd2, 1'b1);
    chk("sc_re", bus.mem_re, 1'b1);
    chk("sc_addr", bus.mem_addr, 16'h0040);
    idle();
    chk("sc_re_off", bus.mem_re, 1'b0);
    idle();
    chk("sc_we3", bus.we3, 1'b1);
    chk("sc_flags", {bus.wsflag, bus.ldsflag}, 2'b11);
    chk("sc_a3", bus.a3, 4'd2);
    chk("sc_wd3", bus.wd3, 48'h0000000000A5);
    idle();
    step(1'b1, 16'hFFFD, 4'd9, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("wrap_addr", bus.mem_addr, wexp[i]);
      idle();
    end
    idle(); idle();
    step(1'b1, 16'h1234, 4'd7, 1'b1);
    chk("ill_err", bus.err, 1'b1);
    chk("ill_re", bus.mem_re, 1'b0);
    chk("ill_ready", bus.req_ready, 1'b0);
    idle();
    chk("ill_ready2", bus.req_ready, 1'b1);
    chk("ill_err_off", bus.err, 1'b0);
    for (int i = 0; i < 6; i++) mem[16'h0200 + i] = 8'(8'h81 + i);
    step(1'b1, 16'h0200, 4'd5, 1'b0);
    idle(); idle(); idle();
    rst_cycles(1);
    chk("rst_re", bus.mem_re, 1'b0);
    chk("rst_wd3", bus.wd3, 48'h0);
    repeat (10) idle();
    a = cyc;
    step(1'b1, 16'h0200, 4'd5, 1'b0);
    repeat (7) idle();
    chk("rst_next_wd3", bus.wd3, 48'h868584838281);
    chk("rst_next_a3", bus.a3, 4'd5);
    idle();
    last = -1;
    for (int i = 0; i < 28; i++) begin
      if (bus.req_ready) begin
        if (last >= 0) chk("b2b_gap", 64'(cyc - last), 64'd9);
        last = cyc;
      end
      step(1'b1, 16'($urandom), 4'($urandom), 1'b0);
    end
    repeat (10) idle();
    while (cyc < MAXC - 200) begin
      if ($urandom_range(0, 199) == 0) rst_cycles($urandom_range(1, 2));
      else step($urandom_range(0, 2) != 0,
                ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom),
                4'($urandom), $urandom_range(0, 3) == 0);
    end
    repeat (12) idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
